game_ctrl_1a2b: RTL and testbench

//  Game controller for the 1A2B board game; sits directly upstream of the A/B compare

---
 rtl/game_ctrl_1a2b.sv | 247 ++++++++++++++++++++++++
 tb/tb_game_ctrl_1a2b.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_1a2b.sv
// game_ctrl_1a2b -- 1A2B board game controller.
// Draws a secret answer from LFSR nibbles and collects four guess digits on
// enter pulses. It presents answer/guess to the downstream A/B compare stage,
// latches the resulting counts and drives four BCD nibbles to the 7-seg mux.
// Optional build macro: GAME_DUP_CHECK_EN. When defined, a guess digit that
// repeats an already-accepted digit of the current guess is ignored.
// The LFSR input is named rand_val because "rand" is a reserved word.
module game_ctrl_1a2b #(
   parameter int MAX_TRIES   = 64,
   parameter int MAX_GUESSES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        enter,
   input  logic [3:0]  in,
   input  logic [15:0] rand_val,
   input  logic [2:0]  a_cnt,
   input  logic [2:0]  b_cnt,
   output logic [15:0] answer,
   output logic [15:0] guess,
   output logic [15:0] disp,
   output logic [3:0]  disp_en,
   output logic        win,
   output logic [3:0]  attempts
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_GUESS,
      S_CHECK,
      S_RESULT,
      S_WIN,
      S_LOSE
   } state_t;

   localparam logic [7:0]  TRY_LAST     = 8'(MAX_TRIES - 1);
   localparam logic [3:0]  GUESS_LIMIT  = 4'(MAX_GUESSES);
   localparam logic [15:0] FALLBACK_ANS = 16'h1234;
   localparam logic [15:0] SPLASH       = 16'h1A2B;

   state_t      state_q, state_d;
   logic [15:0] answer_q, answer_d;
   logic [15:0] guess_q, guess_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic [7:0]  try_cnt_q, try_cnt_d;
   logic [3:0]  attempts_q, attempts_d;
   logic [2:0]  a_q, a_d;
   logic [2:0]  b_q, b_d;
   logic [15:0] disp_q, disp_d;
   logic [3:0]  disp_en_q, disp_en_d;
   logic        win_q, win_d;

   logic        rand_ok;
   logic        digit_dup;
   logic        digit_ok;

   // All four candidate nibbles must be decimal and pairwise distinct
   function automatic logic nibbles_ok(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (v[i*4 +: 4] > 4'd9) begin
            ok = 1'b0;
         end
         for (int j = i + 1; j < 4; j++) begin
            if (v[i*4 +: 4] == v[j*4 +: 4]) begin
               ok = 1'b0;
            end
         end
      end
      return ok;
   endfunction

   // Accepted digits live in the low n nibbles because digits shift in from the right
   function automatic logic digit_seen(input logic [15:0] g, input logic [2:0] n,
                                       input logic [3:0] d);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((i < int'(n)) && (g[i*4 +: 4] == d)) begin
            seen = 1'b1;
         end
      end
      return seen;
   endfunction

   // Qualify the LFSR sample and the incoming guess digit
   always_comb begin
      rand_ok   = nibbles_ok(rand_val);
      digit_dup = digit_seen(guess_q, dcnt_q, in);
`ifdef GAME_DUP_CHECK_EN
      digit_ok  = enter && (in <= 4'd9) && !digit_dup;
`else
      digit_ok  = enter && (in <= 4'd9);
`endif
   end

   // State register plus all datapath and output flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         answer_q   <= 16'h0000;
         guess_q    <= 16'h0000;
         dcnt_q     <= 3'd0;
         try_cnt_q  <= 8'd0;
         attempts_q <= 4'd0;
         a_q        <= 3'd0;
         b_q        <= 3'd0;
         disp_q     <= SPLASH;
         disp_en_q  <= 4'hF;
         win_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         answer_q   <= answer_d;
         guess_q    <= guess_d;
         dcnt_q     <= dcnt_d;
         try_cnt_q  <= try_cnt_d;
         attempts_q <= attempts_d;
         a_q        <= a_d;
         b_q        <= b_d;
         disp_q     <= disp_d;
         disp_en_q  <= disp_en_d;
         win_q      <= win_d;
      end
   end

   // Next-state and datapath updates; start overrides everything, including enter
   always_comb begin
      state_d    = state_q;
      answer_d   = answer_q;
      guess_d    = guess_q;
      dcnt_d     = dcnt_q;
      try_cnt_d  = try_cnt_q;
      attempts_d = attempts_q;
      a_d        = a_q;
      b_d        = b_q;
      if (start) begin
         state_d    = S_INIT;
         guess_d    = 16'h0000;
         dcnt_d     = 3'd0;
         try_cnt_d  = 8'd0;
         attempts_d = 4'd0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (rand_ok) begin
                  answer_d = rand_val;
                  state_d  = S_GUESS;
               end else if (try_cnt_q == TRY_LAST) begin
                  answer_d = FALLBACK_ANS;
                  state_d  = S_GUESS;
               end else begin
                  try_cnt_d = try_cnt_q + 8'd1;
               end
            end
            S_GUESS: begin
               if (digit_ok) begin
                  guess_d = {guess_q[11:0], in};
                  dcnt_d  = dcnt_q + 3'd1;
                  if (dcnt_q == 3'd3) begin
                     state_d = S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               a_d = a_cnt;
               b_d = b_cnt;
               if (attempts_q != 4'hF) begin
                  attempts_d = attempts_q + 4'd1;
               end
               state_d = S_RESULT;
            end
            S_RESULT: begin
               if (enter) begin
                  if (a_q == 3'd4) begin
                     state_d = S_WIN;
                  end else if (attempts_q == GUESS_LIMIT) begin
                     state_d = S_LOSE;
                  end else begin
                     state_d = S_GUESS;
                     guess_d = 16'h0000;
                     dcnt_d  = 3'd0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Display and win flag computed from the upcoming state so they register alongside it
   always_comb begin
      disp_d    = SPLASH;
      disp_en_d = 4'hF;
      win_d     = 1'b0;
      case (state_d)
         S_IDLE: begin
            disp_d    = SPLASH;
            disp_en_d = 4'hF;
         end
         S_INIT: begin
            disp_d    = 16'h0000;
            disp_en_d = 4'h0;
         end
         S_GUESS: begin
            disp_d = guess_d;
            case (dcnt_d)
               3'd0:    disp_en_d = 4'b0000;
               3'd1:    disp_en_d = 4'b0001;
               3'd2:    disp_en_d = 4'b0011;
               3'd3:    disp_en_d = 4'b0111;
               default: disp_en_d = 4'b1111;
            endcase
         end
         S_CHECK: begin
            disp_d    = guess_d;
            disp_en_d = 4'hF;
         end
         S_RESULT: begin
            disp_d    = {1'b0, a_d, 4'hA, 1'b0, b_d, 4'hB};
            disp_en_d = 4'hF;
         end
         S_WIN: begin
            disp_d    = answer_d;
            disp_en_d = 4'hF;
            win_d     = 1'b1;
         end
         S_LOSE: begin
            disp_d    = answer_d;
            disp_en_d = 4'hF;
         end
         default: begin
         end
      endcase
   end

   assign answer   = answer_q;
   assign guess    = guess_q;
   assign disp     = disp_q;
   assign disp_en  = disp_en_q;
   assign win      = win_q;
   assign attempts = attempts_q;

endmodule

// File: tb/tb_game_ctrl_1a2b.sv
// tb_game_ctrl_1a2b -- randomized bench for game_ctrl_1a2b with a game-level
// reference model. The bench also plays the role of the A/B compare stage.
module tb_game_ctrl_1a2b;

   localparam int MAX_TRIES   = 64;
   localparam int MAX_GUESSES = 8;

   localparam int PH_IDLE   = 0;
   localparam int PH_INIT   = 1;
   localparam int PH_GUESS  = 2;
   localparam int PH_CHECK  = 3;
   localparam int PH_RESULT = 4;
   localparam int PH_WIN    = 5;
   localparam int PH_LOSE   = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        enter;
   logic [3:0]  inDigit;
   logic [15:0] randVal;
   logic [2:0]  aCnt;
   logic [2:0]  bCnt;
   logic [15:0] answer;
   logic [15:0] guess;
   logic [15:0] disp;
   logic [3:0]  dispEn;
   logic        win;
   logic [3:0]  attempts;

   // Game-level model of what the player should see
   int          mPhase;
   logic [15:0] mAnswer;
   int          mDigits[$];
   int          mAttempts;
   int          mTries;
   int          mA;
   int          mB;

   int          checkCount = 0;
   int          passCount  = 0;

   game_ctrl_1a2b #(.MAX_TRIES(MAX_TRIES), .MAX_GUESSES(MAX_GUESSES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .enter    (enter),
      .in       (inDigit),
      .rand_val (randVal),
      .a_cnt    (aCnt),
      .b_cnt    (bCnt),
      .answer   (answer),
      .guess    (guess),
      .disp     (disp),
      .disp_en  (dispEn),
      .win      (win),
      .attempts (attempts)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [15:0] packGuess();
      logic [15:0] g;
      g = 16'h0000;
      foreach (mDigits[i]) g = {g[11:0], 4'(mDigits[i])};
      return g;
   endfunction

   function automatic bit validNibbles(input logic [15:0] v);
      bit seen[10];
      int n;
      foreach (seen[i]) seen[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n = int'(v[k*4 +: 4]);
         if (n > 9) return 1'b0;
         if (seen[n]) return 1'b0;
         seen[n] = 1'b1;
      end
      return 1'b1;
   endfunction

   function automatic void computeAB(input logic [15:0] ans, input logic [15:0] gs,
                                     output int a, output int b);
      a = 0;
      b = 0;
      for (int i = 0; i < 4; i++) begin
         if (ans[i*4 +: 4] == gs[i*4 +: 4]) begin
            a++;
         end else begin
            for (int j = 0; j < 4; j++) begin
               if (j != i && ans[j*4 +: 4] == gs[i*4 +: 4]) begin
                  b++;
                  break;
               end
            end
         end
      end
   endfunction

   function automatic logic [15:0] expDisp();
      case (mPhase)
         PH_IDLE:   return 16'h1A2B;
         PH_INIT:   return 16'h0000;
         PH_GUESS:  return packGuess();
         PH_RESULT: return {1'b0, 3'(mA), 4'hA, 1'b0, 3'(mB), 4'hB};
         PH_WIN:    return mAnswer;
         PH_LOSE:   return mAnswer;
         default:   return packGuess();
      endcase
   endfunction

   function automatic logic [3:0] expEn();
      case (mPhase)
         PH_INIT:  return 4'h0;
         PH_GUESS: return 4'((1 << mDigits.size()) - 1);
         default:  return 4'hF;
      endcase
   endfunction

   function automatic logic [15:0] validRand();
      int pool[10];
      int k;
      int t;
      foreach (pool[i]) pool[i] = i;
      for (int i = 9; i > 0; i--) begin
         k = int'($urandom_range(i, 0));
         t = pool[i];
         pool[i] = pool[k];
         pool[k] = t;
      end
      return {4'(pool[0]), 4'(pool[1]), 4'(pool[2]), 4'(pool[3])};
   endfunction

   function automatic logic [15:0] invalidRand();
      logic [15:0] v;
      for (int i = 0; i < 100; i++) begin
         v = 16'($urandom);
         if (!validNibbles(v)) return v;
      end
      return 16'hFFFF;
   endfunction

   // Advance the game-level model by one clock using the rules of play
   task automatic modelStep(input bit st, input bit en, input int d, input logic [15:0] r,
                            input int aIn, input int bIn);
      bit dup;
      if (st) begin
         mPhase = PH_INIT;
         mDigits.delete();
         mAttempts = 0;
         mTries = 0;
         return;
      end
      case (mPhase)
         PH_INIT: begin
            if (validNibbles(r)) begin
               mAnswer = r;
               mPhase = PH_GUESS;
            end else if (mTries == MAX_TRIES - 1) begin
               mAnswer = 16'h1234;
               mPhase = PH_GUESS;
            end else begin
               mTries++;
            end
         end
         PH_GUESS: begin
            dup = 1'b0;
`ifdef GAME_DUP_CHECK_EN
            foreach (mDigits[i]) if (mDigits[i] == d) dup = 1'b1;
`endif
            if (en && d <= 9 && !dup) begin
               mDigits.push_back(d);
               if (mDigits.size() == 4) mPhase = PH_CHECK;
            end
         end
         PH_CHECK: begin
            mA = aIn;
            mB = bIn;
            if (mAttempts < 15) mAttempts++;
            mPhase = PH_RESULT;
         end
         PH_RESULT: begin
            if (en) begin
               if (mA == 4) begin
                  mPhase = PH_WIN;
               end else if (mAttempts == MAX_GUESSES) begin
                  mPhase = PH_LOSE;
               end else begin
                  mPhase = PH_GUESS;
                  mDigits.delete();
               end
            end
         end
         default: begin
         end
      endcase
   endtask

   task automatic checkAll();
      checkOutput("answer", answer, mAnswer);
      checkOutput("guess", guess, packGuess());
      checkOutput("disp", disp, expDisp());
      checkOutput("disp_en", {12'h000, dispEn}, {12'h000, expEn()});
      checkOutput("win", {15'h0000, win}, {15'h0000, (mPhase == PH_WIN)});
      checkOutput("attempts", {12'h000, attempts}, 16'(mAttempts));
   endtask

   // Drive one clock of stimulus from a negedge, then check at the next negedge
   task automatic applyStimulus(input bit st, input bit en, input int d, input logic [15:0] r);
      int a;
      int b;
      computeAB(mAnswer, packGuess(), a, b);
      aCnt    = 3'(a);
      bCnt    = 3'(b);
      start   = st;
      enter   = en;
      inDigit = 4'(d);
      randVal = r;
      @(posedge clk);
      modelStep(st, en, d, r, a, b);
      @(negedge clk);
      checkAll();
   endtask

   task automatic applyReset(input bit st, input bit en);
      rst   = 1'b1;
      start = st;
      enter = en;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      enter = 1'b0;
      mPhase = PH_IDLE;
      mAnswer = 16'h0000;
      mDigits.delete();
      mAttempts = 0;
      mTries = 0;
      mA = 0;
      mB = 0;
      checkAll();
   endtask

   task automatic enterGuess(input int d0, input int d1, input int d2, input int d3);
      applyStimulus(1'b0, 1'b1, d0, 16'h0000);
      applyStimulus(1'b0, 1'b1, d1, 16'h0000);
      applyStimulus(1'b0, 1'b1, d2, 16'h0000);
      applyStimulus(1'b0, 1'b1, d3, 16'h0000);
   endtask

   // Pick one cycle of random stimulus suited to the game phase
   task automatic randomStep();
      bit          st;
      bit          en;
      int          d;
      int          sel;
      logic [15:0] r;
      st = 1'b0;
      en = 1'($urandom_range(1, 0));
      d  = int'($urandom_range(15, 0));
      r  = invalidRand();
      case (mPhase)
         PH_IDLE: st = ($urandom_range(3, 0) == 0);
         PH_INIT: if ($urandom_range(3, 0) == 0) r = validRand();
         PH_GUESS: begin
            en  = ($urandom_range(3, 0) != 0);
            sel = int'($urandom_range(7, 0));
            if (sel == 0)      d = int'($urandom_range(15, 10));
            else if (sel <= 4) d = int'(mAnswer[(3 - mDigits.size())*4 +: 4]);
            else               d = int'($urandom_range(9, 0));
            st = ($urandom_range(79, 0) == 0);
         end
         PH_WIN, PH_LOSE: st = ($urandom_range(5, 0) == 0);
         default: begin
         end
      endcase
      applyStimulus(st, en, d, r);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; enter = 1'b0; inDigit = 4'h0; randVal = 16'h0000;
      aCnt = 3'd0; bCnt = 3'd0;
      mPhase = PH_IDLE; mAnswer = 16'h0000; mAttempts = 0; mTries = 0; mA = 0; mB = 0;
      @(negedge clk);

      // reset state, and enter is ignored while idle
      applyReset(1'b0, 1'b0);
      checkOutput("reset_disp", disp, 16'h1A2B);
      applyStimulus(1'b0, 1'b1, 3, 16'h1234);
      applyStimulus(1'b0, 1'b0, 0, 16'h1234);

      // one rejected draw, then an accepted one
      applyStimulus(1'b1, 1'b0, 0, 16'hAB12);
      applyStimulus(1'b0, 1'b0, 0, 16'hAB12);
      applyStimulus(1'b0, 1'b0, 0, 16'h5739);
      checkOutput("draw_answer", answer, 16'h5739);

      // winning guess
      enterGuess(5, 7, 3, 9);
      applyStimulus(1'b0, 1'b1, 2, 16'h0000);
      checkOutput("win_result_disp", disp, 16'h4A0B);
      applyStimulus(1'b0, 1'b1, 0, 16'h0000);
      checkOutput("win_disp", disp, 16'h5739);
      applyStimulus(1'b0, 1'b1, 4, 16'h0000);

      // out-of-range digit ignored, then guess to exhaustion
      applyStimulus(1'b1, 1'b0, 0, 16'h0000);
      applyStimulus(1'b0, 1'b0, 0, 16'h5739);
      applyStimulus(1'b0, 1'b1, 9, 16'h0000);
      applyStimulus(1'b0, 1'b1, 12, 16'h0000);
      applyStimulus(1'b0, 1'b1, 3, 16'h0000);
      applyStimulus(1'b0, 1'b1, 5, 16'h0000);
      applyStimulus(1'b0, 1'b1, 7, 16'h0000);
      checkOutput("guess_9357", guess, 16'h9357);
      applyStimulus(1'b0, 1'b0, 0, 16'h0000);
      checkOutput("result_0A4B", disp, 16'h0A4B);
      for (int g = 1; g < MAX_GUESSES; g++) begin
         applyStimulus(1'b0, 1'b1, 0, 16'h0000);
         enterGuess(9, 3, 5, 7);
         applyStimulus(1'b0, 1'b0, 0, 16'h0000);
      end
      applyStimulus(1'b0, 1'b1, 0, 16'h0000);
      checkOutput("lose_disp", disp, 16'h5739);
      applyStimulus(1'b0, 1'b1, 1, 16'h0000);

      // answer fallback after MAX_TRIES rejected draws
      applyStimulus(1'b1, 1'b0, 0, 16'h1111);
      for (int k = 0; k < MAX_TRIES; k++) applyStimulus(1'b0, 1'b0, 0, 16'h1111);
      checkOutput("fallback_answer", answer, 16'h1234);

      // repeated digit, then start and enter together
      applyStimulus(1'b0, 1'b1, 2, 16'h0000);
      applyStimulus(1'b0, 1'b1, 2, 16'h0000);
      applyStimulus(1'b0, 1'b1, 4, 16'h0000);
      applyStimulus(1'b1, 1'b1, 6, 16'h1111);
      checkOutput("restart_guess", guess, 16'h0000);

      // reset overrides a concurrent start
      applyReset(1'b1, 1'b1);

      // randomized play
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(599, 0) == 0) applyReset(1'($urandom_range(1, 0)), 1'b1);
         else randomStep();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
